// File: rtl/strobe_period_meter.sv
// strobe_period_meter: measures clk cycles between rising edges of strobe_in.
// Define STROBE_METER_SYNC_EN to pass strobe_in through a 2-flop synchronizer.
module strobe_period_meter #(
    parameter int CNT_WIDTH  = 16,
    parameter int MIN_PERIOD = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 strobe_in,
    output logic [CNT_WIDTH-1:0] period,
    output logic                 period_valid,
    output logic                 timeout,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH:0] MIN_P = (CNT_WIDTH+1)'(MIN_PERIOD);

    // An edge seen at cnt = all ones would wrap to 0; clamp it to all ones instead.
    function automatic logic [CNT_WIDTH-1:0] sat_cnt(input logic [CNT_WIDTH:0] v);
        return v[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : v[CNT_WIDTH-1:0];
    endfunction

    state_t               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] period_q;
    logic                 strobe_prev_q;
    logic                 period_valid_q;
    logic                 timeout_q;
    logic                 busy_q;

    logic                 s;
    logic                 edge_det;
    logic [CNT_WIDTH:0]   cnt_inc;

`ifdef STROBE_METER_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= strobe_in;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;
`else
    assign s = strobe_in;
`endif

    assign edge_det = s & ~strobe_prev_q;
    assign cnt_inc  = {1'b0, cnt_q} + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            period_q       <= '0;
            strobe_prev_q  <= 1'b0;
            period_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            strobe_prev_q  <= s;
            period_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            if (!enable) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= ARM;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                    // The first edge after arming is only a reference point.
                    ARM: begin
                        if (edge_det) begin
                            state_q <= MEASURE;
                            cnt_q   <= '0;
                        end
                    end
                    MEASURE: begin
                        if (edge_det && (cnt_inc >= MIN_P)) begin
                            period_q       <= sat_cnt(cnt_inc);
                            period_valid_q <= 1'b1;
                            cnt_q          <= '0;
                        end else if (&cnt_q) begin
                            timeout_q <= 1'b1;
                            cnt_q     <= '0;
                            state_q   <= ARM;
                        end else begin
                            cnt_q <= cnt_inc[CNT_WIDTH-1:0];
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign timeout      = timeout_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_strobe_period_meter.sv
// Scoreboard bench for strobe_period_meter: two instances (16-bit/min 2, 8-bit/min 4)
// share one stimulus stream and are checked against an interval-based reference model.
module tb_strobe_period_meter;

    localparam int W_A = 16, MIN_A = 2;
    localparam int W_B = 8,  MIN_B = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;
    logic strobe_in = 1'b0;

    logic [W_A-1:0] per_a;
    logic           pv_a, to_a, bz_a;
    logic [W_B-1:0] per_b;
    logic           pv_b, to_b, bz_b;

    strobe_period_meter #(.CNT_WIDTH(W_A), .MIN_PERIOD(MIN_A)) u_a (
        .clk(clk), .reset_n(reset_n), .enable(enable), .strobe_in(strobe_in),
        .period(per_a), .period_valid(pv_a), .timeout(to_a), .busy(bz_a)
    );

    strobe_period_meter #(.CNT_WIDTH(W_B), .MIN_PERIOD(MIN_B)) u_b (
        .clk(clk), .reset_n(reset_n), .enable(enable), .strobe_in(strobe_in),
        .period(per_b), .period_valid(pv_b), .timeout(to_b), .busy(bz_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit is_to;
        int val;
    } ev_t;

    ev_t qa[$];
    ev_t qb[$];

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    bit  mon_en = 1'b0;

    // Reference model: 0 = off, 1 = waiting for reference edge, 2 = timing an interval.
    int  mph[2];
    int  mref[2];
    int  exp_busy[2];
    int  exp_per[2];
    bit  mprev;
    bit  msync[2];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? qa.size() : qb.size();
    endfunction

    function automatic void qpush(input int i, input ev_t e);
        if (i == 0) qa.push_back(e);
        else        qb.push_back(e);
    endfunction

    function automatic ev_t qpop(input int i);
        if (i == 0) return qa.pop_front();
        return qb.pop_front();
    endfunction

    function automatic int qfront_cyc(input int i);
        return (i == 0) ? qa[0].cyc : qb[0].cyc;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            mph[i] = 0; mref[i] = 0; exp_busy[i] = 0; exp_per[i] = 0;
        end
        mprev = 1'b0;
        msync[0] = 1'b0;
        msync[1] = 1'b0;
        qa.delete();
        qb.delete();
    endfunction

    // Evaluate the cycle that ends at this posedge; results are visible in cycle n+1.
    function automatic void model_step();
        int  n = cyc;
        bit  s, e;
        if (!reset_n) begin
            model_reset();
        end else begin
`ifdef STROBE_METER_SYNC_EN
            s = msync[1];
            msync[1] = msync[0];
            msync[0] = strobe_in;
`else
            s = strobe_in;
`endif
            e = s & ~mprev;
            mprev = s;
            for (int i = 0; i < 2; i++) begin
                int w     = (i == 0) ? W_A : W_B;
                int minp  = (i == 0) ? MIN_A : MIN_B;
                int span  = 1 << w;
                int d;
                ev_t ev;
                if (!enable) begin
                    mph[i] = 0;
                end else if (mph[i] == 0) begin
                    mph[i] = 1;
                end else if (mph[i] == 1) begin
                    if (e) begin
                        mref[i] = n;
                        mph[i] = 2;
                    end
                end else begin
                    d = n - mref[i];
                    if (e && d >= minp) begin
                        ev.cyc = n + 1; ev.is_to = 1'b0;
                        ev.val = (d > span - 1) ? span - 1 : d;
                        qpush(i, ev);
                        exp_per[i] = ev.val;
                        mref[i] = n;
                    end else if (d == span) begin
                        ev.cyc = n + 1; ev.is_to = 1'b1; ev.val = 0;
                        qpush(i, ev);
                        mph[i] = 1;
                    end
                end
                exp_busy[i] = (mph[i] != 0) ? 1 : 0;
            end
        end
        cyc = n + 1;
    endfunction

    task automatic mon(input int i, input logic pv, input logic to, input logic bz, input int per);
        ev_t e;
        string tag = (i == 0) ? "a_" : "b_";
        if (pv || to) begin
            chk({tag, "pulse_expected"}, qsize(i), (qsize(i) == 0) ? 1 : qsize(i));
            if (qsize(i) != 0) begin
                e = qpop(i);
                chk({tag, "ev_cycle"}, cyc, e.cyc);
                chk({tag, "ev_timeout"}, int'(to), int'(e.is_to));
                chk({tag, "ev_valid"}, int'(pv), int'(!e.is_to));
                if (!e.is_to) chk({tag, "ev_period"}, per, e.val);
            end
        end else if (qsize(i) != 0 && qfront_cyc(i) <= cyc) begin
            e = qpop(i);
            chk({tag, "missed_pulse"}, int'(pv | to), 1);
        end
        chk({tag, "busy"}, int'(bz), exp_busy[i]);
        chk({tag, "period"}, per, exp_per[i]);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, pv_a, to_a, bz_a, int'(per_a));
            mon(1, pv_b, to_b, bz_b, int'(per_b));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic pulse_gap(input int g);
        strobe_in = 1'b1;
        tick();
        strobe_in = 1'b0;
        repeat (g - 1) tick();
    endtask

    task automatic async_reset();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("rst_async_busy", int'(bz_a | bz_b), 0);
        chk("rst_async_valid", int'(pv_a | pv_b), 0);
        chk("rst_async_timeout", int'(to_a | to_b), 0);
        chk("rst_async_period", int'(per_a) + int'(per_b), 0);
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (3) tick();
        mon_en = 1'b1;
        tick();
        chk("reset_busy", int'(bz_a), 0);
        chk("reset_period", int'(per_a), 0);
        chk("reset_valid", int'(pv_a | to_a), 0);
        reset_n = 1'b1;
        tick();

        // Steady 8-cycle strobe: first edge arms, then five measurements.
        enable = 1'b1;
        tick();
        chk("busy_after_enable", int'(bz_a), 1);
        repeat (6) pulse_gap(8);
        // Period change to 25 cycles.
        repeat (3) pulse_gap(25);
        // Edges at 0, 10, 12, 20, 30: the 12 edge is a glitch for the min-4 instance.
        pulse_gap(10);
        pulse_gap(2);
        pulse_gap(8);
        pulse_gap(10);
        // Long silence: 8-bit instance times out, then re-arms and measures 5.
        pulse_gap(300);
        repeat (3) pulse_gap(5);

        // Drop enable mid-interval, with an edge while disabled.
        pulse_gap(4);
        enable = 1'b0;
        tick();
        chk("busy_after_disable", int'(bz_a), 0);
        chk("period_hold", int'(per_a), 5);
        pulse_gap(3);
        // Re-enable with the strobe already high: no edge.
        strobe_in = 1'b1;
        repeat (4) tick();
        enable = 1'b1;
        repeat (6) tick();
        strobe_in = 1'b0;
        tick();
        repeat (4) pulse_gap(6);

        // Asynchronous reset in the middle of a measurement.
        pulse_gap(3);
        chk("busy_pre_reset", int'(bz_a), 1);
        async_reset();
        tick();

        // Randomised blocks with different strobe densities.
        for (int blk = 0; blk < 12; blk++) begin
            int p;
            case (blk % 4)
                0: p = 40;
                1: p = 8;
                2: p = 0;
                default: p = 3;
            endcase
            for (int k = 0; k < 300; k++) begin
                strobe_in = ($urandom_range(0, 99) < p);
                if ($urandom_range(0, 199) == 0) enable = 1'b0;
                else if (!enable && $urandom_range(0, 9) == 0) enable = 1'b1;
                if ($urandom_range(0, 999) == 0) async_reset();
                tick();
            end
        end

        strobe_in = 1'b0;
        enable = 1'b0;
        repeat (5) tick();
        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
